// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-syncs to an LFSR stream, then free-runs
// a reference LFSR and counts mismatches while locked.
module prbs_checker #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] TAPS     = 4'b1001,
  parameter int               LOCK_CNT = 8,
  parameter int               LOSS_CNT = 3,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  localparam logic [7:0] FILL_N = 8'(WIDTH);
  localparam logic [7:0] LOCK_N = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_N = 8'(LOSS_CNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [7:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [7:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic       pred;
  logic [7:0] match_inc;
  logic [7:0] miss_inc;

  assign pred      = ^(r_q & TAPS);
  assign match_inc = match_q + 8'd1;
  assign miss_inc  = miss_q + 8'd1;

  // Next-state: hunt/lock FSM, shadow shift and error accounting.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          r_d = {r_q[WIDTH-2:0], din};
          if (fill_q != FILL_N) begin
            fill_d = fill_q + 8'd1;
          end else if (din == pred && r_q != '0) begin
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              match_d  = '0;
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          r_d = {r_q[WIDTH-2:0], pred};
          if (din != pred) begin
            err_pulse_d = 1'b1;
            if (!(&err_count_q)) begin
              err_count_d = err_count_q + 1'b1;
            end
            miss_d = miss_inc;
            if (miss_inc == LOSS_N) begin
              state_d  = HUNT;
              locked_d = 1'b0;
              r_d      = r_q;
              fill_d   = '0;
              match_d  = '0;
              miss_d   = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
      if (clear) begin
        err_count_d = '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      r_q         <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker (CNT_W=4) with an
// expected-result queue drained after each clock edge.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid;
  logic       din;
  logic       clear;
  logic       locked;
  logic       err_pulse;
  logic [3:0] err_count;

  typedef struct packed {
    logic       lk;
    logic       ep;
    logic [3:0] ec;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   gi    = 0;
  logic gold [15] = '{1,0,0,0,1,1,1,1,0,1,0,1,1,0,0};

  prbs_checker #(
    .WIDTH   (4),
    .TAPS    (4'b1001),
    .LOCK_CNT(8),
    .LOSS_CNT(3),
    .CNT_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_valid(din_valid),
    .din      (din),
    .clear    (clear),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic nb();
    logic b;
    b  = gold[gi];
    gi = (gi + 1) % 15;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic d,
                      input logic c, input logic el, input logic ep,
                      input logic [3:0] ec);
    exp_t e;
    din_valid = v;
    din       = d;
    clear     = c;
    sb.push_back('{lk: el, ep: ep, ec: ec});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".locked"}, {3'b0, locked}, {3'b0, e.lk});
    chk({tag, ".pulse"}, {3'b0, err_pulse}, {3'b0, e.ep});
    chk({tag, ".count"}, err_count, e.ec);
  endtask

  function automatic logic [3:0] sat(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int vc;
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    clear     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.locked", {3'b0, locked}, 4'd0);
    chk("reset.pulse", {3'b0, err_pulse}, 4'd0);
    chk("reset.count", err_count, 4'd0);
    #2 rst_n = 1'b1;

    for (int k = 1; k <= 60; k++)
      step("lock", 1'b1, nb(), 1'b0, k >= 12, 1'b0, 4'd0);

    step("single_err", 1'b1, ~nb(), 1'b0, 1'b1, 1'b1, 4'd1);
    for (int k = 0; k < 10; k++)
      step("single_after", 1'b1, nb(), 1'b0, 1'b1, 1'b0, 4'd1);

    step("clear_good", 1'b1, nb(), 1'b1, 1'b1, 1'b0, 4'd0);

    step("loss1", 1'b1, ~nb(), 1'b0, 1'b1, 1'b1, 4'd1);
    step("loss2", 1'b1, ~nb(), 1'b0, 1'b1, 1'b1, 4'd2);
    step("loss3", 1'b1, ~nb(), 1'b0, 1'b0, 1'b1, 4'd3);
    for (int k = 1; k <= 14; k++)
      step("relock", 1'b1, nb(), 1'b0, k >= 12, 1'b0, 4'd3);

    for (int i = 1; i <= 16; i++) begin
      step("sat_err", 1'b1, ~nb(), 1'b0, 1'b1, 1'b1, sat(3 + i));
      step("sat_good", 1'b1, nb(), 1'b0, 1'b1, 1'b0, sat(3 + i));
    end
    step("clear_err", 1'b1, ~nb(), 1'b1, 1'b1, 1'b1, 4'd0);
    step("post_clear", 1'b1, nb(), 1'b0, 1'b1, 1'b0, 4'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("async.locked", {3'b0, locked}, 4'd0);
    chk("async.count", err_count, 4'd0);
    chk("async.pulse", {3'b0, err_pulse}, 4'd0);
    #2 rst_n = 1'b1;

    vc = 0;
    while (vc < 14) begin
      vc++;
      step("gap_valid", 1'b1, nb(), 1'b0, vc >= 12, 1'b0, 4'd0);
      step("gap_hold", 1'b0, 1'($urandom_range(1)), 1'b0,
           vc >= 12, 1'b0, 4'd0);
    end

    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 40; k++)
      step("zeros", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial pseudo-random bit-stream checker. It is the receive-side counterpart of the team's Fibonacci PRPG.
- It self-synchronises to an incoming LFSR stream, then free-runs a local reference LFSR and compares every received bit against the prediction.
- It reports lock status, a per-bit error pulse and a saturating error count.
- It is used in BIST and link loopback paths behind the PRPG.

Parameters:
- WIDTH, 4: LFSR length in bits (min 2).
- TAPS, 4'b1001: tap mask, WIDTH bits. The default is x^4+x^3+1. The prediction is the XOR of the shadow bits selected by TAPS.
- LOCK_CNT, 8: consecutive matches required in HUNT to declare lock (1..255).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that drop lock (1..255).
- CNT_W, 16: err_count width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din_valid  in  1  din is sampled on this edge when high. When low, all state holds.
- din  in  1  received serial bit.
- clear  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle pulse per counted mismatch.
- err_count  out  CNT_W  saturating count of mismatches seen in LOCKED.

Behaviour:
- Shadow register r[WIDTH-1:0]. r[0] holds the newest bit. Shift rule: r <= {r[WIDTH-2:0], x}.
- Prediction p = ^(r & TAPS). This matches a generator that outputs s[WIDTH-1] and shifts in fb = ^(s & TAPS).
- Reset (async, rst_n=0):
  - state=HUNT; r=0; fill counter=0; match counter=0; miss counter=0.
  - locked=0; err_pulse=0; err_count=0.
  - Reset mid-operation abandons lock immediately.
- All updates occur only on edges with din_valid=1. err_pulse is 0 on any edge with din_valid=0.
- HUNT state:
  - x=din, so r always loads the received bits.
  - For the first WIDTH valid bits after reset or loss of lock: fill counter increments; no compare.
  - After fill, each valid bit compares din with p.
  - A match with r!=0 increments the match counter.
  - A mismatch, or a match with r==0, clears the match counter. This rejects the degenerate all-zero stream.
  - When the match counter reaches LOCK_CNT: state goes to LOCKED and locked=1 from that edge. Default latency is 12 valid bits.
  - No errors are counted in HUNT; err_pulse stays 0.
- LOCKED state:
  - x=p, so the reference free-runs. A single flipped input bit therefore yields exactly one error.
  - On din!=p: err_pulse=1 for the following cycle; err_count increments, saturating at all-ones; miss counter increments.
  - On din==p: miss counter clears.
  - When the miss counter reaches LOSS_CNT: state goes to HUNT; locked=0 at that same edge; fill, match and miss counters clear.
  - All LOSS_CNT mismatches are counted, including the one that drops lock.
  - r keeps its current value, then shifts received bits from the next valid bit onward.
- clear=1 forces err_count=0 on that edge. This takes priority over a simultaneous increment; err_pulse still fires. clear does not affect state or lock.
- All outputs are registered.

Test Plan:
- Golden sequence for the defaults, seed 1000, period 15: 1,0,0,0,1,1,1,1,0,1,0,1,1,0,0. Each test below feeds this sequence repeatedly unless stated otherwise.
- Lock: feed the golden sequence with din_valid=1 continuously -> locked rises at the edge of valid bit 12; err_count=0 after 60 bits.
- Single error: after lock, invert one bit -> exactly one err_pulse; err_count=1; locked stays 1; later bits match.
- Loss of lock: after lock, feed 3 consecutive inverted bits -> err_count=3; locked=0 on the 3rd; resuming the clean stream relocks 12 valid bits later.
- All-zero and valid gaps: feed 40 zero bits -> locked stays 0. Then feed the golden stream with din_valid toggling 1/0 -> lock after 12 valid bits; the held cycles change nothing.
- Saturation and clear, with CNT_W=4: after lock, feed inverted bits alternating with good bits -> err_count stops at 15. Assert clear on an error edge -> err_count=0 and err_pulse=1.
- Async reset mid-lock: pull rst_n low between edges -> locked=0 and err_count=0 immediately. After release, relock takes 12 valid bits.
